// File: rtl/radix22_frame_sched_if.sv
// Scheduler <-> source/pipeline/sink signal bundle for radix22_frame_sched.
// master = scheduler side, slave = surrounding datapath and bench.
interface radix22_frame_sched_if #(
  parameter int unsigned LOG2N = 4
);
  logic             s_valid;
  logic             s_ready;
  logic             pipe_en;
  logic             pipe_zero;
  logic [LOG2N-1:0] ctrl_cnt;
  logic             m_valid;
  logic             m_ready;
  logic             m_sof;
  logic             m_eof;
  logic             busy;

  modport master (
    input  s_valid, m_ready,
    output s_ready, pipe_en, pipe_zero, ctrl_cnt, m_valid, m_sof, m_eof, busy
  );

  modport slave (
    output s_valid, m_ready,
    input  s_ready, pipe_en, pipe_zero, ctrl_cnt, m_valid, m_sof, m_eof, busy
  );
endinterface

// File: rtl/radix22_frame_sched.sv
// Frame scheduler for the radix-2^2 SDF FFT: gates pipe_en, owns ctrl_cnt, drains with zeros, tags output.
// Optional RADIX22_SCHED_STATS_EN adds frame_cnt_o / stall_cnt_o statistics counters.
module radix22_frame_sched #(
  parameter int unsigned N_POINTS = 16,
  parameter int unsigned PIPE_LAT = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  radix22_frame_sched_if.master bus
`ifdef RADIX22_SCHED_STATS_EN
  ,
  output logic [15:0]           frame_cnt_o,
  output logic [15:0]           stall_cnt_o
`endif
);
  localparam int unsigned LOG2N = $clog2(N_POINTS);
  localparam int unsigned OCC_W = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [LOG2N-1:0]    ctrl_q;
  logic [OCC_W-1:0]    occ_q, occ_d;
  logic [PIPE_LAT-1:0] tv_q, ts_q, te_q;

  logic tail_v, stall, cnt_zero, cnt_last;
  logic accept, adv, zero_fill, ready;

  assign tail_v   = tv_q[PIPE_LAT-1];
  assign stall    = tail_v && !bus.m_ready;
  assign cnt_zero = (ctrl_q == {LOG2N{1'b0}});
  assign cnt_last = (ctrl_q == LOG2N'(N_POINTS - 1));

  // Beat decode: decides whether the pipe advances this cycle and with what input.
  // A result is only consumed on an advancing beat, so m_valid&&m_ready without pipe_en is not a transfer.
  always_comb begin
    accept    = 1'b0;
    adv       = 1'b0;
    zero_fill = 1'b0;
    ready     = 1'b0;
    state_d   = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        ready = !stall;
        if (!stall && bus.s_valid) begin
          accept = 1'b1;
          adv    = 1'b1;
        end else if (!stall && tail_v && !cnt_zero) begin
          adv       = 1'b1;
          zero_fill = 1'b1;
        end else begin
          adv = 1'b0;
        end
        if (state_q == ST_IDLE) begin
          state_d = accept ? ST_RUN : ST_IDLE;
        end else if (!stall && !bus.s_valid && cnt_zero) begin
          state_d = (occ_q != {OCC_W{1'b0}}) ? ST_FLUSH : ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (stall) begin
          zero_fill = 1'b1;
        end else if (bus.s_valid && cnt_zero) begin
          ready   = 1'b1;
          accept  = 1'b1;
          adv     = 1'b1;
          state_d = ST_RUN;
        end else begin
          adv       = 1'b1;
          zero_fill = 1'b1;
          // A waiting source keeps us padding toward the next frame boundary instead of idling misaligned.
          if (!bus.s_valid && (occ_q == OCC_W'(tail_v))) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_FLUSH;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    occ_d = occ_q + OCC_W'(accept) - OCC_W'(adv && tail_v);
  end

  // FSM, stage counter, occupancy and the {v,sof,eof} tag shift register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      ctrl_q  <= {LOG2N{1'b0}};
      occ_q   <= {OCC_W{1'b0}};
      tv_q    <= {PIPE_LAT{1'b0}};
      ts_q    <= {PIPE_LAT{1'b0}};
      te_q    <= {PIPE_LAT{1'b0}};
    end else begin
      state_q <= state_d;
      occ_q   <= occ_d;
      if (adv) begin
        ctrl_q  <= ctrl_q + LOG2N'(1);
        tv_q[0] <= accept;
        ts_q[0] <= accept && cnt_zero;
        te_q[0] <= accept && cnt_last;
        for (int i = 1; i < PIPE_LAT; i++) begin
          tv_q[i] <= tv_q[i-1];
          ts_q[i] <= ts_q[i-1];
          te_q[i] <= te_q[i-1];
        end
      end else begin
        ctrl_q <= ctrl_q;
      end
    end
  end

  assign bus.s_ready   = ready;
  assign bus.pipe_en   = adv && rst;
  assign bus.pipe_zero = zero_fill && rst;
  assign bus.ctrl_cnt  = ctrl_q;
  assign bus.m_valid   = tail_v;
  assign bus.m_sof     = tail_v && ts_q[PIPE_LAT-1];
  assign bus.m_eof     = tail_v && te_q[PIPE_LAT-1];
  assign bus.busy      = (state_q != ST_IDLE) || (occ_q != {OCC_W{1'b0}});

`ifdef RADIX22_SCHED_STATS_EN
  logic [15:0] frame_cnt_q, stall_cnt_q;

  // Completed-frame counter (wraps) and stall-cycle counter (saturates).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt_q <= 16'd0;
      stall_cnt_q <= 16'd0;
    end else begin
      if (adv && tail_v && te_q[PIPE_LAT-1]) begin
        frame_cnt_q <= frame_cnt_q + 16'd1;
      end else begin
        frame_cnt_q <= frame_cnt_q;
      end
      if (stall && (stall_cnt_q != 16'hFFFF)) begin
        stall_cnt_q <= stall_cnt_q + 16'd1;
      end else begin
        stall_cnt_q <= stall_cnt_q;
      end
    end
  end

  assign frame_cnt_o = frame_cnt_q;
  assign stall_cnt_o = stall_cnt_q;
`endif
endmodule

// File: tb/tb_radix22_frame_sched.sv
// Directed bench for radix22_frame_sched (N_POINTS=16, PIPE_LAT=20); cycle 1 is the first accept cycle of a run.
module tb_radix22_frame_sched;
  localparam int MAXC = 200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  radix22_frame_sched_if #(.LOG2N(4)) bus ();
`ifdef RADIX22_SCHED_STATS_EN
  logic [15:0] frame_cnt, stall_cnt;
`endif

  radix22_frame_sched #(.N_POINTS(16), .PIPE_LAT(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef RADIX22_SCHED_STATS_EN
    ,
    .frame_cnt_o (frame_cnt),
    .stall_cnt_o (stall_cnt)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;
  int lg_pe[MAXC], lg_pz[MAXC], lg_sr[MAXC], lg_ctrl[MAXC], lg_occ[MAXC];
  int first_mv, beats, idle_cyc, zero_beats;
  int sof_q[$];
  int eof_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic reset_dut();
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // Drives n_samp samples with an optional s_valid gap and m_ready drop, logs each cycle until idle.
  task automatic run_seq(input int n_samp, input int gap_at, input int gap_len,
                         input int stall_at, input int stall_len);
    int acc;
    acc = 0; first_mv = 0; beats = 0; idle_cyc = 0; zero_beats = 0;
    sof_q.delete();
    eof_q.delete();
    for (int c = 1; c < MAXC; c++) begin
      bus.s_valid = (acc < n_samp) && !(c >= gap_at && c < gap_at + gap_len);
      bus.m_ready = !(c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      lg_pe[c]   = int'(bus.pipe_en);
      lg_pz[c]   = int'(bus.pipe_zero);
      lg_sr[c]   = int'(bus.s_ready);
      lg_ctrl[c] = int'(bus.ctrl_cnt);
      lg_occ[c]  = int'(dut.occ_q);
      if (bus.s_valid && bus.s_ready) acc++;
      if (bus.pipe_en && bus.pipe_zero) zero_beats++;
      if (bus.m_valid && first_mv == 0) first_mv = c;
      if (bus.pipe_en && bus.m_valid) begin
        beats++;
        if (bus.m_sof) sof_q.push_back(beats);
        if (bus.m_eof) eof_q.push_back(beats);
      end
      if (acc == n_samp && !bus.busy) begin
        idle_cyc = c;
        break;
      end
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    check_eq("run_done", 32'(idle_cyc != 0), 32'd1);
  endtask

  task automatic check_stream(input string tag, input int n_fr, input int exp_first);
    check_eq({tag, "_first_mv"}, first_mv, exp_first);
    check_eq({tag, "_beats"}, beats, n_fr * 16);
    check_eq({tag, "_nsof"}, sof_q.size(), n_fr);
    check_eq({tag, "_neof"}, eof_q.size(), n_fr);
    for (int f = 0; f < sof_q.size() && f < n_fr; f++)
      check_eq({tag, "_sof_beat"}, sof_q[f], f * 16 + 1);
    for (int f = 0; f < eof_q.size() && f < n_fr; f++)
      check_eq({tag, "_eof_beat"}, eof_q[f], f * 16 + 16);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // Power-on reset with a pending sample: nothing may advance.
    rst         = 1'b0;
    bus.s_valid = 1'b1;
    bus.m_ready = 1'b1;
    #2;
    check_eq("por_s_ready", 32'(bus.s_ready), 32'd1);
    check_eq("por_pipe_en", 32'(bus.pipe_en), 32'd0);
    check_eq("por_pipe_zero", 32'(bus.pipe_zero), 32'd0);
    check_eq("por_ctrl", 32'(bus.ctrl_cnt), 32'd0);
    check_eq("por_m_valid", 32'(bus.m_valid), 32'd0);
    check_eq("por_busy", 32'(bus.busy), 32'd0);
    reset_dut();

    // Two back-to-back frames, then flush: accepts 1..32, hold 33, zeros 34..53, idle 54.
    run_seq(32, 0, 0, 0, 0);
    check_stream("cont", 2, 21);
    check_eq("cont_hold_pe", lg_pe[33], 32'd0);
    check_eq("cont_zero_beats", zero_beats, 32'd20);
    check_eq("cont_idle_cyc", idle_cyc, 32'd54);
    check_eq("cont_end_ctrl", lg_ctrl[idle_cyc], 32'd4);
    for (int c = 21; c <= 33; c++) check_eq("steady_occ", lg_occ[c], 32'd20);
`ifdef RADIX22_SCHED_STATS_EN
    check_eq("frame_cnt", 32'(frame_cnt), 32'd2);
`endif

    // Source gap of 3 cycles after sample 5.
    reset_dut();
    run_seq(16, 6, 3, 0, 0);
    for (int c = 6; c <= 8; c++) begin
      check_eq("gap_pe", lg_pe[c], 32'd0);
      check_eq("gap_ctrl", lg_ctrl[c], 32'd5);
    end
    check_stream("gap", 1, 25);

    // Downstream stall of 4 cycles starting at cycle 23 (ctrl_cnt = 22 mod 16).
    reset_dut();
    run_seq(32, 0, 0, 23, 4);
    for (int c = 23; c <= 26; c++) begin
      check_eq("stall_s_ready", lg_sr[c], 32'd0);
      check_eq("stall_pe", lg_pe[c], 32'd0);
      check_eq("stall_ctrl", lg_ctrl[c], 32'd6);
    end
    check_stream("stall", 2, 21);
`ifdef RADIX22_SCHED_STATS_EN
    check_eq("stall_cnt", 32'(stall_cnt), 32'd4);
`endif

    // Source returns during FLUSH at ctrl_cnt=7 (cycle 25); must pad until ctrl_cnt=0 (cycle 34).
    reset_dut();
    run_seq(32, 17, 8, 0, 0);
    check_eq("refl_ctrl25", lg_ctrl[25], 32'd7);
    check_eq("refl_sready25", lg_sr[25], 32'd0);
    check_eq("refl_zero25", lg_pz[25], 32'd1);
    check_eq("refl_sready33", lg_sr[33], 32'd0);
    check_eq("refl_sready34", lg_sr[34], 32'd1);
    check_eq("refl_zero34", lg_pz[34], 32'd0);
    check_eq("refl_ctrl34", lg_ctrl[34], 32'd0);
    check_stream("reflush", 2, 22);

    // Asynchronous reset in the middle of a frame.
    reset_dut();
    bus.s_valid = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("mid_pre_ctrl", 32'(bus.ctrl_cnt), 32'd8);
    check_eq("mid_pre_pe", 32'(bus.pipe_en), 32'd1);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_ctrl", 32'(bus.ctrl_cnt), 32'd0);
    check_eq("mid_s_ready", 32'(bus.s_ready), 32'd1);
    check_eq("mid_pipe_en", 32'(bus.pipe_en), 32'd0);
    check_eq("mid_busy", 32'(bus.busy), 32'd0);
    check_eq("mid_m_valid", 32'(bus.m_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
